disp_wta_select: RTL and testbench
==================================

// Module: disp_wta_select
// PURPOSE
// - Winner-take-all stage of the SGBM pipeline, directly upstream of the result-RAM writer.
// - Consumes aggregated path costs serially: one beat per candidate disparity, d = 0..MAX_DISP-1, per pixel.
// - Selects the minimum-cost disparity and applies a uniqueness-ratio check.
// - Emits one {disparity, row, col, valid} result per pixel in raster order, 2 cycles after the pixel's last cost beat.
// PARAMETERS
// IMG_W        400            pixels per row; col wraps at IMG_W-1
// IMG_H        200            rows per frame; row wraps at IMG_H-1
// MAX_DISP     64             cost beats per pixel; legal range 2..1024
// COST_W       16             aggregated cost width, unsigned
// UNIQ_PCT     10             uniqueness ratio in percent; legal range 0..99
// INVALID_DISP 32'h0000_FFFF  disparity code emitted for rejected pixels
// PORTS
// clk        in   1       clock
// rst        in   1       reset
// cost_in    in   COST_W  aggregated cost for the current candidate d
// cost_valid in   1       cost_in valid this cycle; bubbles allowed anywhere
// cost_first in   1       qualifies the beat carrying d=0
// cost_last  in   1       qualifies the beat carrying d=MAX_DISP-1
// disparity  out  32      selected d zero-extended, or INVALID_DISP
// row_out    out  10      row of the emitted pixel
// col_out    out  10      col of the emitted pixel
// valid      out  1       1-cycle strobe; the downstream stage has no backpressure
// frame_done out  1       1-cycle strobe with valid, only for pixel (IMG_H-1, IMG_W-1)
// err_seq    out  1       sticky beat-protocol error flag
// BEHAVIOUR
// - Reset: rst is synchronous, active-high; clock is clk.
// - Reset values: disparity=0, row_out=0, col_out=0, valid=0, frame_done=0, err_seq=0.
// - Reset also clears the raster counters and the d counter, and enters IDLE.
// - Reset mid-pixel: the partial pixel and any in-flight pipeline result are discarded; nothing is emitted.
// - FSM IDLE: waits for a beat with cost_first.
//   - Beats without cost_first in IDLE set err_seq and are dropped.
// - cost_first beat: min=cost_in, idx=0, sec=all-ones, d=1, next state ACCUM.
// - ACCUM, each beat:
//   - if cost_in < min (strict; ties keep the lower d): sec=min, min=cost_in, idx=d.
//   - else if cost_in < sec: sec=cost_in.
//   - d increments by 1.
// - Pixel close: a beat with cost_last AND d==MAX_DISP-1 pushes {min, sec, idx} to stage 1 and returns to IDLE.
//   - The next pixel's cost_first may arrive the very next cycle.
// - Protocol errors (err_seq set, stays set until rst):
//   - cost_last at d != MAX_DISP-1: pixel dropped; go to IDLE.
//   - d reaches MAX_DISP-1 without cost_last: pixel dropped; go to IDLE.
//   - cost_first inside ACCUM: current pixel dropped; this beat restarts a new pixel.
//   - Dropped pixels never advance row/col.
// - Stage 2 uniqueness check, in COST_W+7-bit unsigned arithmetic:
//   - reject when sec*(100-UNIQ_PCT) < min*100.
//   - otherwise disparity = {zeros, idx}.
// - Latency: the cost_last beat is sampled at edge N; valid is high in the cycle after edge N+2.
//   - Full throughput: one result per MAX_DISP beats.
// - Raster: col increments after each emitted pixel.
//   - col==IMG_W-1 wraps to 0 and row increments.
//   - (IMG_H-1, IMG_W-1) wraps to (0,0); frame_done pulses with that pixel's valid.
// - Outputs hold their last values while valid=0.
// STRUCTURE
// - Shared package sgbm_pkg holds: IMG_W, IMG_H, MAX_DISP, COST_W, INVALID_DISP, and localparam DISP_IDX_W = clog2(MAX_DISP).
// - Sub-module wta_min2_tracker holds the running min / second-min / index registers plus the compare logic.
// - The top level holds the FSM, the d counter, the uniqueness stage and the raster counters.
// TESTING
// - Single pixel:
//   - stimulus: all costs 200, cost[17]=50.
//   - response: disparity=17, row_out=0, col_out=0, valid 2 cycles after the last beat.
// - Uniqueness reject (UNIQ_PCT=10):
//   - stimulus: cost[5]=100, cost[40]=105, others 300.
//   - response: 105*90 < 10000, so disparity=32'h0000_FFFF.
// - Tie (UNIQ_PCT=0):
//   - stimulus: cost[3]=cost[9]=20, others 500.
//   - response: disparity=3.
// - Full frame:
//   - stimulus: 80000 pixels, random 0-3 cycle bubbles.
//   - response: raster coordinates; the last result is (199,399) with frame_done=1; the next result is (0,0).
// - Protocol error:
//   - stimulus: cost_last on beat 30, then one good pixel.
//   - response: err_seq=1, no valid for the bad pixel, the good pixel gets col_out=0.
// - Reset mid-pixel:
//   - stimulus: rst after 20 beats of the pixel at (0,5).
//   - response: no valid; the next pixel is reported at (0,0); err_seq=0.

Source files
------------

// File: rtl/sgbm_pkg.sv
// Shared SGBM definitions: frame geometry, cost width, disparity coding and
// the winner-take-all FSM state type.
// No ports; imported by the SGBM pipeline stages.
package sgbm_pkg;

    localparam int unsigned IMG_W      = 400;
    localparam int unsigned IMG_H      = 200;
    localparam int unsigned MAX_DISP   = 64;
    localparam int unsigned COST_W     = 16;
    localparam int unsigned DISP_IDX_W = $clog2(MAX_DISP);

    // sec*(100-pct) and min*100 both fit because 100 < 2**7
    localparam int unsigned UNIQ_W     = COST_W + 7;

    localparam logic [31:0] INVALID_DISP = 32'h0000_FFFF;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } wta_state_e;

endpackage

// File: rtl/wta_min2_tracker.sv
// Running minimum / second-minimum / arg-min tracker for one pixel's cost beats.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   load              first beat of a pixel: min=cost, sec=all-ones, idx=0
//   upd               further beat at candidate d
//   cost, d           current cost and its candidate disparity
//   min_cost, sec_cost, min_idx   registered tracker state
module wta_min2_tracker
    import sgbm_pkg::*;
#(
    parameter int unsigned IDX_W = DISP_IDX_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              upd,
    input  logic [COST_W-1:0] cost,
    input  logic [IDX_W-1:0]  d,
    output logic [COST_W-1:0] min_cost,
    output logic [COST_W-1:0] sec_cost,
    output logic [IDX_W-1:0]  min_idx
);

    logic lt_min_s;
    logic lt_sec_s;

    // Strict compares: a tie with the current minimum keeps the lower d.
    always_comb begin
        lt_min_s = (cost < min_cost);
        lt_sec_s = (cost < sec_cost);
    end

    // Min / second-min / index registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            min_cost <= {COST_W{1'b0}};
            sec_cost <= {COST_W{1'b1}};
            min_idx  <= {IDX_W{1'b0}};
        end else if (load) begin
            min_cost <= cost;
            sec_cost <= {COST_W{1'b1}};
            min_idx  <= {IDX_W{1'b0}};
        end else if (upd) begin
            if (lt_min_s) begin
                sec_cost <= min_cost;
                min_cost <= cost;
                min_idx  <= d;
            end else if (lt_sec_s) begin
                sec_cost <= cost;
            end
        end
    end

endmodule

// File: rtl/disp_wta_select.sv
// Winner-take-all disparity selection with uniqueness-ratio check.
// Consumes one cost beat per candidate d (0..MAX_DISP-1) per pixel and emits
// one {disparity, row, col} result per pixel, two cycles after the last beat.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   cost_in/valid/first/last  serial aggregated cost beats (bubbles allowed)
//   disparity                 chosen d zero-extended, or INVALID_DISP
//   row_out, col_out          raster position of the emitted pixel
//   valid                     1-cycle result strobe (no backpressure)
//   frame_done                strobe with valid for the last pixel of a frame
//   err_seq                   sticky beat-protocol error flag
module disp_wta_select
    import sgbm_pkg::*;
#(
    parameter int unsigned IMG_W    = sgbm_pkg::IMG_W,
    parameter int unsigned IMG_H    = sgbm_pkg::IMG_H,
    parameter int unsigned MAX_DISP = sgbm_pkg::MAX_DISP,
    parameter int unsigned UNIQ_PCT = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [COST_W-1:0] cost_in,
    input  logic              cost_valid,
    input  logic              cost_first,
    input  logic              cost_last,
    output logic [31:0]       disparity,
    output logic [9:0]        row_out,
    output logic [9:0]        col_out,
    output logic              valid,
    output logic              frame_done,
    output logic              err_seq
);

    localparam int unsigned       IDX_W    = $clog2(MAX_DISP);
    localparam logic [IDX_W-1:0]  D_LAST   = IDX_W'(MAX_DISP - 1);
    localparam logic [9:0]        COL_LAST = 10'(IMG_W - 1);
    localparam logic [9:0]        ROW_LAST = 10'(IMG_H - 1);
    localparam logic [UNIQ_W-1:0] KEEP_MUL = UNIQ_W'(100 - UNIQ_PCT);
    localparam logic [UNIQ_W-1:0] HUNDRED  = UNIQ_W'(100);

    wta_state_e        state_r;
    logic [IDX_W-1:0]  d_r;
    logic              close_r;
    logic              load_s;
    logic              upd_s;
    logic [COST_W-1:0] min_cost_s;
    logic [COST_W-1:0] sec_cost_s;
    logic [IDX_W-1:0]  min_idx_s;
    logic              s1_valid_r;
    logic [UNIQ_W-1:0] s1_sec_x_r;
    logic [UNIQ_W-1:0] s1_min_x_r;
    logic [IDX_W-1:0]  s1_idx_r;
    logic [9:0]        row_cnt_r;
    logic [9:0]        col_cnt_r;

    // Tracker control: any cost_first beat (re)starts a pixel; other beats
    // only count while a pixel is open.
    always_comb begin
        load_s = 1'b0;
        upd_s  = 1'b0;
        if (cost_valid) begin
            load_s = cost_first;
            upd_s  = (!cost_first) && (state_r == ST_ACCUM);
        end else begin
            load_s = 1'b0;
            upd_s  = 1'b0;
        end
    end

    wta_min2_tracker #(
        .IDX_W(IDX_W)
    ) u_tracker (
        .clk      (clk),
        .rst      (rst),
        .load     (load_s),
        .upd      (upd_s),
        .cost     (cost_in),
        .d        (d_r),
        .min_cost (min_cost_s),
        .sec_cost (sec_cost_s),
        .min_idx  (min_idx_s)
    );

    // Beat-protocol FSM, d counter and sticky error flag. close_r marks the
    // cycle in which the tracker holds a complete, well-formed pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            d_r     <= {IDX_W{1'b0}};
            close_r <= 1'b0;
            err_seq <= 1'b0;
        end else begin
            close_r <= 1'b0;
            if (cost_valid) begin
                if (cost_first) begin
                    // Restart inside ACCUM drops the open pixel; a beat that
                    // is both first and last cannot be a legal pixel.
                    if ((state_r == ST_ACCUM) || cost_last) begin
                        err_seq <= 1'b1;
                    end
                    state_r <= cost_last ? ST_IDLE : ST_ACCUM;
                    d_r     <= IDX_W'(1);
                end else if (state_r == ST_IDLE) begin
                    err_seq <= 1'b1;
                end else if (cost_last) begin
                    state_r <= ST_IDLE;
                    d_r     <= {IDX_W{1'b0}};
                    if (d_r == D_LAST) begin
                        close_r <= 1'b1;
                    end else begin
                        err_seq <= 1'b1;
                    end
                end else if (d_r == D_LAST) begin
                    state_r <= ST_IDLE;
                    d_r     <= {IDX_W{1'b0}};
                    err_seq <= 1'b1;
                end else begin
                    d_r <= d_r + IDX_W'(1);
                end
            end
        end
    end

    // Stage 1: capture the closed pixel and form both sides of the ratio test.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_sec_x_r <= {UNIQ_W{1'b0}};
            s1_min_x_r <= {UNIQ_W{1'b0}};
            s1_idx_r   <= {IDX_W{1'b0}};
        end else begin
            s1_valid_r <= close_r;
            if (close_r) begin
                s1_sec_x_r <= UNIQ_W'(sec_cost_s) * KEEP_MUL;
                s1_min_x_r <= UNIQ_W'(min_cost_s) * HUNDRED;
                s1_idx_r   <= min_idx_s;
            end
        end
    end

    // Stage 2: uniqueness decision, registered outputs and raster counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            disparity  <= 32'd0;
            row_out    <= 10'd0;
            col_out    <= 10'd0;
            valid      <= 1'b0;
            frame_done <= 1'b0;
            row_cnt_r  <= 10'd0;
            col_cnt_r  <= 10'd0;
        end else begin
            valid <= s1_valid_r;
            if (s1_valid_r) begin
                disparity  <= (s1_sec_x_r < s1_min_x_r) ? INVALID_DISP : 32'(s1_idx_r);
                row_out    <= row_cnt_r;
                col_out    <= col_cnt_r;
                frame_done <= (row_cnt_r == ROW_LAST) && (col_cnt_r == COL_LAST);
                if (col_cnt_r == COL_LAST) begin
                    col_cnt_r <= 10'd0;
                    row_cnt_r <= (row_cnt_r == ROW_LAST) ? 10'd0 : row_cnt_r + 10'd1;
                end else begin
                    col_cnt_r <= col_cnt_r + 10'd1;
                end
            end else begin
                frame_done <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_disp_wta_select.sv
// Testbench for disp_wta_select. Two instances share one beat stream: one with
// UNIQ_PCT=10 and one with UNIQ_PCT=0. A small frame keeps full-frame runs short.
module tb_disp_wta_select;

    localparam int TW = 7;
    localparam int TH = 3;
    localparam int MD = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cost_in;
    logic        cost_valid, cost_first, cost_last;
    logic [31:0] disp_a, disp_b;
    logic [9:0]  row_a, col_a, row_b, col_b;
    logic        valid_a, valid_b, fd_a, fd_b, err_a, err_b;

    always #5 clk = ~clk;

    disp_wta_select #(.IMG_W(TW), .IMG_H(TH), .MAX_DISP(MD), .UNIQ_PCT(10)) dut_a (
        .clk(clk), .rst(rst), .cost_in(cost_in), .cost_valid(cost_valid),
        .cost_first(cost_first), .cost_last(cost_last), .disparity(disp_a),
        .row_out(row_a), .col_out(col_a), .valid(valid_a), .frame_done(fd_a),
        .err_seq(err_a));

    disp_wta_select #(.IMG_W(TW), .IMG_H(TH), .MAX_DISP(MD), .UNIQ_PCT(0)) dut_b (
        .clk(clk), .rst(rst), .cost_in(cost_in), .cost_valid(cost_valid),
        .cost_first(cost_first), .cost_last(cost_last), .disparity(disp_b),
        .row_out(row_b), .col_out(col_b), .valid(valid_b), .frame_done(fd_b),
        .err_seq(err_b));

    typedef struct {
        logic [31:0] ea;
        logic [31:0] eb;
        int          row;
        int          col;
        bit          fd;
        longint      due;
    } exp_t;

    typedef struct {
        int          base;
        int          i1;
        int          v1;
        int          i2;
        int          v2;
        logic [31:0] ea;
        logic [31:0] eb;
    } vec_t;

    int     n_vec = 0;
    int     n_err = 0;
    longint cyc   = 0;
    int     pix_cost[MD];
    int     pix_n = 0;
    exp_t   exp_q[$];
    vec_t   tbl[9];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Output monitor: every strobe must match the oldest expected result on time.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (valid_a || valid_b) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 64'(valid_a | valid_b), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("latency", 64'(cyc), 64'(e.due));
                    check("valid_b", 64'(valid_b), 64'd1);
                    check("disp_a", 64'(disp_a), 64'(e.ea));
                    check("disp_b", 64'(disp_b), 64'(e.eb));
                    check("row_a", 64'(row_a), 64'(e.row));
                    check("col_a", 64'(col_a), 64'(e.col));
                    check("row_b", 64'(row_b), 64'(e.row));
                    check("col_b", 64'(col_b), 64'(e.col));
                    check("fd_a", 64'(fd_a), 64'(e.fd));
                    check("fd_b", 64'(fd_b), 64'(e.fd));
                end
            end else begin
                if (exp_q.size() != 0 && cyc > exp_q[0].due) begin
                    check("missing_valid", 64'(cyc), 64'(exp_q[0].due));
                    void'(exp_q.pop_front());
                end
                if (fd_a || fd_b) check("fd_without_valid", 64'(fd_a | fd_b), 64'd0);
            end
        end
    end

    task automatic beat(input int c, input bit f, input bit l);
        cost_in    = 16'(c);
        cost_first = f;
        cost_last  = l;
        cost_valid = 1'b1;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        cost_valid = 1'b0;
        cost_first = 1'b0;
        cost_last  = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        cost_valid = 1'b0;
        cost_first = 1'b0;
        cost_last  = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        pix_n = 0;
    endtask

    task automatic set_pattern(input int base, input int i1, input int v1, input int i2, input int v2);
        for (int d = 0; d < MD; d++) pix_cost[d] = base;
        pix_cost[i1] = v1;
        pix_cost[i2] = v2;
    endtask

    task automatic random_pattern();
        int mode;
        int rng;
        mode = int'($urandom_range(0, 3));
        rng  = (mode == 0) ? 15 : (mode == 1) ? 300 : 65535;
        for (int d = 0; d < MD; d++) pix_cost[d] = int'($urandom_range(0, rng));
        if (mode == 3) pix_cost[$urandom_range(0, MD - 1)] = int'($urandom_range(0, 50));
    endtask

    // Reference: sort the costs; min and second-min are the two smallest
    // values, the index is the lowest d holding the minimum.
    function automatic logic [31:0] model_disp(input int pct);
        int q[$];
        int mn, sc, idx;
        for (int d = 0; d < MD; d++) q.push_back(pix_cost[d]);
        q.sort();
        mn  = q[0];
        sc  = q[1];
        idx = 0;
        for (int d = MD - 1; d >= 0; d--) if (pix_cost[d] == mn) idx = d;
        if (longint'(sc) * longint'(100 - pct) < longint'(mn) * 100) return 32'h0000_FFFF;
        return 32'(idx);
    endfunction

    task automatic send_pixel(input int gap_max, input logic [31:0] ea, input logic [31:0] eb, input bit push);
        exp_t e;
        for (int d = 0; d < MD; d++) begin
            if (d == MD - 1 && push) begin
                e.ea  = ea;
                e.eb  = eb;
                e.row = (pix_n / TW) % TH;
                e.col = pix_n % TW;
                e.fd  = (pix_n % (TW * TH)) == (TW * TH - 1);
                e.due = cyc + 3;
                exp_q.push_back(e);
                pix_n++;
            end
            beat(pix_cost[d], d == 0, d == MD - 1);
            if (gap_max > 0) idle(int'($urandom_range(0, gap_max)));
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 12 && exp_q.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{200,   17, 50,    17, 50,    32'd17,         32'd17};
        tbl[1] = '{300,    5, 100,   40, 105,   32'h0000_FFFF,  32'd5};
        tbl[2] = '{500,    3, 20,     9, 20,    32'h0000_FFFF,  32'd3};
        tbl[3] = '{1000,  63, 0,     63, 0,     32'd63,         32'd63};
        tbl[4] = '{65535,  0, 65535,  0, 65535, 32'h0000_FFFF,  32'd0};
        tbl[5] = '{100,    0, 89,     0, 89,    32'd0,          32'd0};
        tbl[6] = '{100,    0, 91,     0, 91,    32'h0000_FFFF,  32'd0};
        tbl[7] = '{7,     62, 6,     63, 6,     32'h0000_FFFF,  32'd62};
        tbl[8] = '{0,      0, 0,      0, 0,     32'd0,          32'd0};

        rst        = 1'b1;
        cost_in    = 16'd0;
        cost_valid = 1'b0;
        cost_first = 1'b0;
        cost_last  = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_disp_a", 64'(disp_a), 64'd0);
        check("rst_row_a", 64'(row_a), 64'd0);
        check("rst_col_a", 64'(col_a), 64'd0);
        check("rst_valid_a", 64'(valid_a), 64'd0);
        check("rst_fd_a", 64'(fd_a), 64'd0);
        check("rst_err_a", 64'(err_a), 64'd0);
        check("rst_disp_b", 64'(disp_b), 64'd0);
        check("rst_err_b", 64'(err_b), 64'd0);

        // Directed table, back-to-back pixels at full throughput
        for (int i = 0; i < 9; i++) begin
            set_pattern(tbl[i].base, tbl[i].i1, tbl[i].v1, tbl[i].i2, tbl[i].v2);
            send_pixel(0, tbl[i].ea, tbl[i].eb, 1'b1);
        end
        idle(1);
        drain();
        check("table_err_a", 64'(err_a), 64'd0);
        check("table_err_b", 64'(err_b), 64'd0);

        // Protocol errors: early last, restart inside a pixel, missing last
        do_reset();
        for (int d = 0; d <= 30; d++) beat(100, d == 0, d == 30);
        idle(4);
        check("early_last_err_a", 64'(err_a), 64'd1);
        check("early_last_err_b", 64'(err_b), 64'd1);
        set_pattern(200, 17, 50, 17, 50);
        send_pixel(0, 32'd17, 32'd17, 1'b1);
        for (int d = 0; d < 10; d++) beat(50, d == 0, 1'b0);
        set_pattern(1000, 63, 0, 63, 0);
        send_pixel(0, 32'd63, 32'd63, 1'b1);
        for (int d = 0; d < MD; d++) beat(1, d == 0, 1'b0);
        idle(2);
        set_pattern(200, 17, 50, 17, 50);
        send_pixel(0, 32'd17, 32'd17, 1'b1);
        idle(1);
        drain();
        check("sticky_err_a", 64'(err_a), 64'd1);

        // Reset mid-pixel at (0,5) and with a result in flight
        do_reset();
        check("reset_clears_err_a", 64'(err_a), 64'd0);
        for (int p = 0; p < 5; p++) begin
            random_pattern();
            send_pixel(0, model_disp(10), model_disp(0), 1'b1);
        end
        idle(1);
        drain();
        for (int d = 0; d < 20; d++) beat(10, d == 0, 1'b0);
        do_reset();
        idle(6);
        set_pattern(200, 17, 50, 17, 50);
        send_pixel(0, 32'd17, 32'd17, 1'b0);
        do_reset();
        idle(6);
        send_pixel(0, 32'd17, 32'd17, 1'b1);
        idle(1);
        drain();
        check("mid_reset_err_a", 64'(err_a), 64'd0);
        check("mid_reset_err_b", 64'(err_b), 64'd0);

        // Randomized frames with bubbles, across two frame wraps
        do_reset();
        for (int p = 0; p < 2 * TW * TH + 3; p++) begin
            random_pattern();
            send_pixel(3, model_disp(10), model_disp(0), 1'b1);
        end
        idle(1);
        drain();
        check("frame_err_a", 64'(err_a), 64'd0);
        check("frame_err_b", 64'(err_b), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
